// File: rtl/exe_stage_module.sv
// Execute stage and EXE/MEM pipeline register: forwarding, Val2
// generation, ALU with NZCV flags, branch target, status register.
module exe_stage_module #(
  parameter int ADDR_W = 32,
  parameter int REG_W  = 32,
  parameter int RA_W   = 4,
  parameter int IMM_W  = 24,
  parameter int SHOP_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [3:0]        status_reg_in,
  input  logic [REG_W-1:0]  reg_file_out1_in,
  input  logic [REG_W-1:0]  reg_file_out2_in,
  input  logic [1:0]        sel_src1,
  input  logic [1:0]        sel_src2,
  input  logic [REG_W-1:0]  mem_fwd_data,
  input  logic [REG_W-1:0]  wb_fwd_data,
  input  logic [IMM_W-1:0]  signed_immediate_in,
  input  logic [SHOP_W-1:0] shift_operand_in,
  input  logic              is_immediate_in,
  input  logic              status_write_enable_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              wb_enable_in,
  input  logic              is_branch_in,
  input  logic [3:0]        execute_command_in,
  input  logic [RA_W-1:0]   dest_reg_in,
  output logic              branch_taken,
  output logic [ADDR_W-1:0] branch_address,
  output logic [3:0]        status_out,
  output logic [REG_W-1:0]  alu_result_out,
  output logic [REG_W-1:0]  store_value_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic              wb_enable_out,
  output logic [RA_W-1:0]   dest_reg_out
);

  function automatic logic [REG_W-1:0] ror(
    input logic [REG_W-1:0] x,
    input logic [4:0]       n
  );
    if (n == 5'd0) return x;
    return (x >> n) | (x << (REG_W - 32'(n)));
  endfunction

  logic [REG_W-1:0] op1, op2raw, val2;
  logic [REG_W-1:0] alu_b, alu_res;
  logic [REG_W:0]   sum;
  logic             alu_ci, is_arith;
  logic [3:0]       nzcv;
  logic             c_in;
  logic [4:0]       sh_amt;

  assign c_in   = status_reg_in[1];
  assign sh_amt = shift_operand_in[11:7];

  always_comb begin
    case (sel_src1)
      2'b01:   op1 = mem_fwd_data;
      2'b10:   op1 = wb_fwd_data;
      default: op1 = reg_file_out1_in;
    endcase
    case (sel_src2)
      2'b01:   op2raw = mem_fwd_data;
      2'b10:   op2raw = wb_fwd_data;
      default: op2raw = reg_file_out2_in;
    endcase
  end

  always_comb begin
    val2 = op2raw;
    if (mem_read_in | mem_write_in) begin
      val2 = {{(REG_W-SHOP_W){1'b0}}, shift_operand_in};
    end else if (is_immediate_in) begin
      val2 = ror({{(REG_W-8){1'b0}}, shift_operand_in[7:0]},
                 {shift_operand_in[11:8], 1'b0});
    end else begin
      case (shift_operand_in[6:5])
        2'b00:   val2 = op2raw << sh_amt;
        2'b01:   val2 = op2raw >> sh_amt;
        2'b10:   val2 = REG_W'($signed(op2raw) >>> sh_amt);
        default: val2 = ror(op2raw, sh_amt);
      endcase
    end
  end

  // Subtraction runs through the adder as op1 + ~Val2 + carry-in,
  // so the adder carry-out is directly the ARM "no borrow" C flag.
  always_comb begin
    alu_b    = val2;
    alu_ci   = 1'b0;
    is_arith = 1'b0;
    case (execute_command_in)
      4'b0010: is_arith = 1'b1;
      4'b0011: begin is_arith = 1'b1; alu_ci = c_in; end
      4'b0100: begin is_arith = 1'b1; alu_b = ~val2; alu_ci = 1'b1; end
      4'b0101: begin is_arith = 1'b1; alu_b = ~val2; alu_ci = c_in; end
      default: ;
    endcase
    sum = {1'b0, op1} + {1'b0, alu_b} + {{REG_W{1'b0}}, alu_ci};
    case (execute_command_in)
      4'b0001: alu_res = val2;
      4'b1001: alu_res = ~val2;
      4'b0110: alu_res = op1 & val2;
      4'b0111: alu_res = op1 | val2;
      4'b1000: alu_res = op1 ^ val2;
      default: alu_res = is_arith ? sum[REG_W-1:0] : '0;
    endcase
    nzcv[3] = alu_res[REG_W-1];
    nzcv[2] = (alu_res == '0);
    nzcv[1] = is_arith ? sum[REG_W] : status_reg_in[1];
    nzcv[0] = is_arith
            ? ((op1[REG_W-1] == alu_b[REG_W-1]) &&
               (alu_res[REG_W-1] != op1[REG_W-1]))
            : status_reg_in[0];
  end

  assign branch_taken   = is_branch_in;
  assign branch_address = pc_in +
    ({{(ADDR_W-IMM_W){signed_immediate_in[IMM_W-1]}},
      signed_immediate_in} << 2);

  logic [3:0]       status_q, status_d;
  logic [REG_W-1:0] alu_q, store_q;
  logic             mr_q, mw_q, wb_q;
  logic [RA_W-1:0]  dst_q;

  assign status_d = status_write_enable_in ? nzcv : status_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= '0;
      alu_q    <= '0;
      store_q  <= '0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
      wb_q     <= 1'b0;
      dst_q    <= '0;
    end else if (!freeze) begin
      status_q <= status_d;
      alu_q    <= alu_res;
      store_q  <= op2raw;
      mr_q     <= mem_read_in;
      mw_q     <= mem_write_in;
      wb_q     <= wb_enable_in;
      dst_q    <= dest_reg_in;
    end
  end

  assign status_out      = status_q;
  assign alu_result_out  = alu_q;
  assign store_value_out = store_q;
  assign mem_read_out    = mr_q;
  assign mem_write_out   = mw_q;
  assign wb_enable_out   = wb_q;
  assign dest_reg_out    = dst_q;

endmodule

// File: tb/tb_exe_stage_module.sv
// Randomized self-checking bench for exe_stage_module against
// an arithmetic reference model of the execute-stage rules.
module tb_exe_stage_module;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze;
  logic [31:0] pc_in;
  logic [3:0]  status_reg_in;
  logic [31:0] rf1, rf2, mem_fwd, wb_fwd;
  logic [1:0]  sel1, sel2;
  logic [23:0] simm;
  logic [11:0] shop;
  logic        is_imm, swe, mr, mw, wbe, isb;
  logic [3:0]  cmd;
  logic [3:0]  dst;

  logic        br_taken;
  logic [31:0] br_addr;
  logic [3:0]  stat;
  logic [31:0] alu_o, store_o;
  logic        mr_o, mw_o, wb_o;
  logic [3:0]  dst_o;

  exe_stage_module dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .pc_in(pc_in), .status_reg_in(status_reg_in),
    .reg_file_out1_in(rf1), .reg_file_out2_in(rf2),
    .sel_src1(sel1), .sel_src2(sel2),
    .mem_fwd_data(mem_fwd), .wb_fwd_data(wb_fwd),
    .signed_immediate_in(simm), .shift_operand_in(shop),
    .is_immediate_in(is_imm), .status_write_enable_in(swe),
    .mem_read_in(mr), .mem_write_in(mw), .wb_enable_in(wbe),
    .is_branch_in(isb), .execute_command_in(cmd),
    .dest_reg_in(dst),
    .branch_taken(br_taken), .branch_address(br_addr),
    .status_out(stat), .alu_result_out(alu_o),
    .store_value_out(store_o), .mem_read_out(mr_o),
    .mem_write_out(mw_o), .wb_enable_out(wb_o),
    .dest_reg_out(dst_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] e_alu, e_store;
  logic        e_mr, e_mw, e_wb;
  logic [3:0]  e_dst, e_stat;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] s,
                                       input logic [31:0] r);
    if (s == 2'd1) return mem_fwd;
    if (s == 2'd2) return wb_fwd;
    return r;
  endfunction

  function automatic logic [31:0] rot1(input logic [31:0] x,
                                       input int n);
    logic [31:0] y = x;
    for (int i = 0; i < n; i++) y = {y[0], y[31:1]};
    return y;
  endfunction

  function automatic logic [31:0] m_val2();
    logic [31:0] x = pick(sel2, rf2);
    int amt = int'(shop[11:7]);
    if (mr || mw) return {20'd0, shop};
    if (is_imm) return rot1({24'd0, shop[7:0]}, 2 * int'(shop[11:8]));
    case (shop[6:5])
      2'b00: return 32'(longint'(x) * (longint'(1) << amt));
      2'b01: return x / (32'd1 << amt);
      2'b10: begin
        for (int i = 0; i < amt; i++) x = {x[31], x[31:1]};
        return x;
      end
      default: return rot1(x, amt);
    endcase
  endfunction

  function automatic longint sx(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  task automatic model(output logic [31:0] res, output logic [3:0] f);
    logic [31:0] a = pick(sel1, rf1);
    logic [31:0] b = m_val2();
    longint ci = longint'(status_reg_in[1]);
    longint u, s;
    logic arith = 1'b1;
    u = 0; s = 0;
    case (cmd)
      4'd2: begin u = a + longint'(b);      s = sx(a) + sx(b); end
      4'd3: begin u = a + longint'(b) + ci; s = sx(a) + sx(b) + ci; end
      4'd4: begin
        u = a + (64'hFFFFFFFF - b) + 1; s = sx(a) - sx(b);
      end
      4'd5: begin
        u = a + (64'hFFFFFFFF - b) + ci; s = sx(a) - sx(b) - (1 - ci);
      end
      default: arith = 1'b0;
    endcase
    case (cmd)
      4'd1:    res = b;
      4'd9:    res = ~b;
      4'd6:    res = a & b;
      4'd7:    res = a | b;
      4'd8:    res = a ^ b;
      default: res = arith ? u[31:0] : 32'd0;
    endcase
    f[3] = res[31];
    f[2] = (res == 32'd0);
    f[1] = arith ? (u >= 64'h1_0000_0000) : status_reg_in[1];
    f[0] = arith ? (s > 64'sd2147483647 || s < -64'sd2147483648)
                 : status_reg_in[0];
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".alu"},   alu_o,   e_alu);
    chk({tag, ".store"}, store_o, e_store);
    chk({tag, ".ctl"},   {29'd0, mr_o, mw_o, wb_o},
                         {29'd0, e_mr, e_mw, e_wb});
    chk({tag, ".dst"},   {28'd0, dst_o}, {28'd0, e_dst});
    chk({tag, ".stat"},  {28'd0, stat},  {28'd0, e_stat});
  endtask

  task automatic step(input string tag);
    logic [31:0] r;
    logic [3:0]  f;
    longint off;
    #1;
    off = longint'($signed(simm));
    chk({tag, ".br_addr"}, br_addr, 32'(longint'(pc_in) + off * 4));
    chk({tag, ".br_tk"}, {31'd0, br_taken}, {31'd0, isb});
    model(r, f);
    if (!freeze) begin
      e_alu   = r;
      e_store = pick(sel2, rf2);
      e_mr = mr; e_mw = mw; e_wb = wbe;
      e_dst = dst;
      if (swe) e_stat = f;
    end
    @(posedge clk);
    #1;
    chk_regs(tag);
    @(negedge clk);
  endtask

  task automatic rand_in();
    pc_in = $urandom; status_reg_in = 4'($urandom);
    rf1 = $urandom; rf2 = $urandom;
    mem_fwd = $urandom; wb_fwd = $urandom;
    sel1 = 2'($urandom); sel2 = 2'($urandom);
    simm = 24'($urandom); shop = 12'($urandom);
    is_imm = 1'($urandom); swe = 1'($urandom);
    mr = ($urandom_range(0, 5) == 0);
    mw = ($urandom_range(0, 5) == 0);
    wbe = 1'($urandom); isb = 1'($urandom);
    cmd = 4'($urandom); dst = 4'($urandom);
    freeze = ($urandom_range(0, 7) == 0);
    if ($urandom_range(0, 3) == 0) begin
      rf1 = 32'h7FFFFFFF + 32'($urandom_range(0, 2));
      rf2 = rf1 ^ 32'($urandom_range(0, 1));
    end
  endtask

  task automatic base_in();
    freeze = 0; pc_in = 0; status_reg_in = 0;
    rf1 = 0; rf2 = 0; mem_fwd = 0; wb_fwd = 0;
    sel1 = 0; sel2 = 0; simm = 0; shop = 0;
    is_imm = 0; swe = 0; mr = 0; mw = 0; wbe = 0; isb = 0;
    cmd = 0; dst = 0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    e_alu = 0; e_store = 0; e_mr = 0; e_mw = 0; e_wb = 0;
    e_dst = 0; e_stat = 0;
    chk_regs(tag);
    #1 rst = 1'b0;
  endtask

  logic [31:0] snap_alu;
  logic [3:0]  snap_stat;

  initial begin
    rand_in();
    #2 rst = 1'b1;
    #1;
    e_alu = 0; e_store = 0; e_mr = 0; e_mw = 0; e_wb = 0;
    e_dst = 0; e_stat = 0;
    chk_regs("reset");
    @(negedge clk);
    rst = 1'b0;

    base_in();
    cmd = 4'b0001; is_imm = 1; shop = 12'h4FF; swe = 1;
    status_reg_in = 4'b0011; wbe = 1; dst = 4'd3;
    step("mov_imm");
    chk("imm_rot", alu_o, 32'hFF000000);
    chk("imm_nzcv", {28'd0, stat}, 32'hB);

    base_in();
    cmd = 4'b0100; rf1 = 5; rf2 = 7; swe = 1; wbe = 1;
    step("sub");
    chk("sub_res", alu_o, 32'hFFFFFFFE);
    chk("sub_nzcv", {28'd0, stat}, 32'h8);

    base_in();
    cmd = 4'b0100; rf1 = 7; rf2 = 7; swe = 1;
    step("cmp");
    chk("cmp_nzcv", {28'd0, stat}, 32'h6);

    base_in();
    cmd = 4'b0010; sel1 = 2'b01; mem_fwd = 32'h7FFFFFFF;
    is_imm = 1; shop = 12'h001; swe = 1;
    step("add_ovf");
    chk("ovf_res", alu_o, 32'h80000000);
    chk("ovf_nzcv", {28'd0, stat}, 32'h9);

    base_in();
    cmd = 4'b0010; mr = 1; shop = 12'h004; rf1 = 32'h100;
    wbe = 1; isb = 1; pc_in = 32'h20; simm = 24'hFFFFFE;
    #1 chk("br_18", br_addr, 32'h18);
    step("ldr");
    chk("ldr_addr", alu_o, 32'h104);
    chk("ldr_mr", {31'd0, mr_o}, 32'd1);

    snap_alu = e_alu; snap_stat = e_stat;
    for (int i = 0; i < 3; i++) begin
      rand_in();
      freeze = 1; swe = 1;
      step("freeze");
    end
    chk("frz_alu", alu_o, snap_alu);
    chk("frz_stat", {28'd0, stat}, {28'd0, snap_stat});
    base_in();
    cmd = 4'b0001; is_imm = 1; shop = 12'h012;
    step("release");
    chk("rel_alu", alu_o, 32'h12);

    for (int i = 0; i < 400; i++) begin
      rand_in();
      if ($urandom_range(0, 63) == 0) do_reset("rst_mid");
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/exe_stage_module.md
Name: exe_stage_module

Overview:
- Execute stage plus EXE/MEM pipeline register for the ARM-subset 5-stage pipeline.
- Consumes the fields registered by the decode stage register, forwards operands, and generates Val2 from the shifter operand or immediate.
- Computes the ALU result, NZCV flags and branch target, owns the status register, and registers results toward the memory stage.

Parameters:
- ADDR_W, 32, PC/address width
- REG_W, 32, register/data width
- RA_W, 4, register-address width
- IMM_W, 24, signed branch immediate width
- SHOP_W, 12, shift-operand width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- freeze  in  1  hold all registers (memory-stage stall)
- pc_in  in  ADDR_W  PC+4 of instruction in EXE
- status_reg_in  in  4  flag snapshot {N,Z,C,V} carried with instruction
- reg_file_out1_in, reg_file_out2_in  in  REG_W  Rn, Rm/Rd values from decode register
- sel_src1, sel_src2  in  2  forwarding select: 00 reg file, 01 mem_fwd_data, 10 wb_fwd_data, 11 reg file
- mem_fwd_data, wb_fwd_data  in  REG_W  forwarded results
- signed_immediate_in  in  IMM_W  branch offset (words)
- shift_operand_in  in  SHOP_W  shifter operand / offset12
- is_immediate_in, status_write_enable_in, mem_read_in, mem_write_in, wb_enable_in, is_branch_in  in  1 each  controls
- execute_command_in  in  4  ALU op
- dest_reg_in  in  RA_W  destination register
- branch_taken  out  1  combinational, equals is_branch_in
- branch_address  out  ADDR_W  combinational branch target
- status_out  out  4  status register (to decode condition check)
- alu_result_out  out  REG_W  registered ALU result / memory address
- store_value_out  out  REG_W  registered forwarded src2 value (STR data)
- mem_read_out, mem_write_out, wb_enable_out  out  1 each  registered controls
- dest_reg_out  out  RA_W  registered destination

Behaviour:
- Reset (async, immediate): every registered output = 0; status register = 0.
- Operand forwarding: op1 is selected by sel_src1 from reg_file_out1_in, mem_fwd_data or wb_fwd_data. op2raw is selected by sel_src2 from reg_file_out2_in, mem_fwd_data or wb_fwd_data.
- Val2 generation, in priority order:
  - If mem_read_in|mem_write_in: zero-extend shift_operand_in[11:0].
  - Else if is_immediate_in: imm8 = [7:0], rotated right by 2*[11:8], 32-bit rotate.
  - Else: op2raw shifted by amount [11:7], type [6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. An amount of 0 passes op2raw unchanged.
- Commands (C_in = status_reg_in[1]):
  - 0001 MOV = Val2
  - 1001 MVN = ~Val2
  - 0010 ADD = op1+Val2
  - 0011 ADC = op1+Val2+C_in
  - 0100 SUB/CMP = op1-Val2
  - 0101 SBC = op1-Val2-~C_in
  - 0110 AND/TST = op1&Val2
  - 0111 ORR = op1|Val2
  - 1000 EOR = op1^Val2
  - Any other code gives result 0, and flags follow the logical rule.
- Flags:
  - N = result[REG_W-1]; Z = (result==0).
  - Arithmetic ops: C = carry-out of the (REG_W+1)-bit sum. Subtraction is computed as op1+~Val2+1, or +C_in for SBC, so C=1 means no borrow. V = signed overflow of the operation.
  - MOV/MVN/logical ops: C and V copy status_reg_in.
- Branch: branch_address = pc_in + (sign-extend(signed_immediate_in) << 2), wrap-around mod 2^ADDR_W. Purely combinational; not gated by freeze.
- Status register:
  - On rising edge with status_write_enable_in=1 and freeze=0, loads {N,Z,C,V}; otherwise holds.
  - status_out always reflects the register, so a new value is visible the cycle after the write.
- Pipeline register: on rising edge with freeze=0, captures alu_result, op2raw (as store_value), controls and dest_reg. Latency is exactly 1 cycle. With freeze=1 all outputs and status hold, regardless of inputs.
- A bubble (all controls 0) propagates as controls 0. Data fields are don't-care but are still captured.
- Reset asserted mid-operation clears everything on that edge-independent assertion. The first capture occurs on the first rising edge after deassertion.

Test Plan:
- Reset: rst=1 with arbitrary inputs -> all registered outputs 0, status_out=4'b0000 without a clock edge.
- Immediate rotate: MOV, is_immediate=1, shift_operand=12'h4FF, status_write_enable=1 -> next cycle alu_result_out=32'hFF000000, status_out N=1 Z=0, C/V copied from status_reg_in.
- Sub borrow: SUB with op1=5, Rm=7, LSL 0, S=1 -> result 32'hFFFFFFFE, NZCV=1000. Then CMP 7,7 -> 0, NZCV=0110.
- Overflow and forwarding: ADD, sel_src1=01, mem_fwd_data=32'h7FFFFFFF, Val2=1 -> result 32'h80000000, NZCV=1001.
- Memory and branch:
  - LDR with shift_operand=12'h004, op1=32'h100 -> alu_result_out=32'h104, mem_read_out=1.
  - Branch pc_in=32'h20, imm=24'hFFFFFE -> branch_address=32'h18 in the same cycle.
- Freeze: freeze=1 for 3 cycles with changing inputs and status_write_enable=1 -> all outputs and status_out unchanged. Release -> the new instruction is captured on the next edge.
